// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush with bubble
// injection and occupancy report. Define PIPE_STAGE_REG_STALL_CNT_EN to add the Stall_Cnt output.
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] BUBBLE_VAL  = {WIDTH{1'b0}},
  parameter int               STALL_CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [WIDTH-1:0] D,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  input  logic             Flush,
  output logic [1:0]       Occupancy
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] Stall_Cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_in_fire;
  logic             w_out_fire;

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("pipe_stage_reg: WIDTH must be >= 1");
    end
    if (STALL_CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_reg: STALL_CNT_W must be >= 1");
    end
  endgenerate

  assign w_in_fire  = In_Valid & In_Ready;
  assign w_out_fire = Out_Valid & Out_Ready;

  // State register
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a flush empties the stage regardless of handshakes
  always_comb begin
    w_state_next = r_state;
    if (Flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_state_next = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            w_state_next = ST_TWO;
          end else if (!w_in_fire && w_out_fire) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_TWO:   if (w_out_fire) w_state_next = ST_ONE;
        default:  w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Outputs decoded from registered state only, so In_Ready has no path from Out_Ready
  always_comb begin
    In_Ready  = (r_state != ST_TWO);
    Out_Valid = (r_state != ST_EMPTY);
    case (r_state)
      ST_ONE:  Occupancy = 2'd1;
      ST_TWO:  Occupancy = 2'd2;
      default: Occupancy = 2'd0;
    endcase
  end

  // Payload registers; SKID is left untouched by a flush since it can never become visible
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_main <= RESET_VAL;
      r_skid <= RESET_VAL;
    end else if (Flush) begin
      r_main <= BUBBLE_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) r_main <= D;
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= D;
          end else if (w_in_fire) begin
            r_skid <= D;
          end
        end
        ST_TWO:   if (w_out_fire) r_main <= r_skid;
        default:  ;
      endcase
    end
  end

  assign Q  = r_main;
  assign Qn = ~r_main;

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles where a live item is held back by downstream
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_stall_cnt <= '0;
    end else if (Out_Valid && !Out_Ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign Stall_Cnt = r_stall_cnt;
`endif

endmodule
